// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

    // Access lifecycle: wait for a request, present it to memory, await completion.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    // Which requester owns the outstanding access.
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // Default number of back-to-back data grants allowed while a fetch waits.
    localparam int STREAK_DEFAULT = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one single-port
// memory with one outstanding access. Data wins by default, but a fetch is
// guaranteed a slot after STREAK consecutive data grants.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DW     = 32,
    parameter int STREAK = STREAK_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    // instruction fetch port
    input  logic          i_valid,
    input  logic [31:0]   i_addr,
    output logic          i_ready,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    output logic          i_abort,
    // data port
    input  logic          d_valid,
    input  logic          d_write,
    input  logic [31:0]   d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ready,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          d_abort,
    // memory port
    output logic          mem_req,
    output logic          mem_we,
    output logic [31:0]   mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_abort
);

    localparam int            SW         = $clog2(STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(STREAK);

    arb_state_t    state_q, state_d;
    owner_t        owner_q;
    logic          we_q;
    logic [31:0]   addr_q;
    logic [DW-1:0] wdata_q;
    logic [SW-1:0] streak_q;
    logic          sel_i, sel_d;
    logic          rsp_done;

    // ---------------- priority / streak selector ----------------
    // Grant data unless a fetch has already been starved for STREAK data grants.
    always_comb begin
        sel_i = 1'b0;
        sel_d = 1'b0;
        if (state_q == ST_IDLE) begin
            if (d_valid && (!i_valid || streak_q < STREAK_MAX))
                sel_d = 1'b1;
            else if (i_valid)
                sel_i = 1'b1;
        end
    end

    assign i_ready  = sel_i;
    assign d_ready  = sel_d;
    assign rsp_done = (state_q == ST_WAIT) && mem_rvalid;

    // Count data grants made while a fetch is pending; any idle fetch cycle forgives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            streak_q <= '0;
        else if (!i_valid || sel_i)
            streak_q <= '0;
        else if (sel_d && streak_q != STREAK_MAX)
            streak_q <= streak_q + SW'(1);
    end

    // ---------------- access FSM ----------------
    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next state and memory command; the command is only visible while issuing.
    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            ST_IDLE: begin
                if (sel_i || sel_d)
                    state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                if (mem_gnt)
                    state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_rvalid)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture the accepted request so the memory command stays stable until granted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q <= OWN_I;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (sel_d) begin
            owner_q <= OWN_D;
            we_q    <= d_write;
            addr_q  <= d_addr;
            wdata_q <= d_wdata;
        end else if (sel_i) begin
            owner_q <= OWN_I;
            we_q    <= 1'b0;
            addr_q  <= i_addr;
            wdata_q <= '0;
        end
    end

    // Route the completion to the owner only; the other port keeps its last response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_rvalid <= 1'b0;
            i_rdata  <= '0;
            i_abort  <= 1'b0;
            d_rvalid <= 1'b0;
            d_rdata  <= '0;
            d_abort  <= 1'b0;
        end else begin
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            if (rsp_done) begin
                if (owner_q == OWN_D) begin
                    d_rvalid <= 1'b1;
                    d_rdata  <= we_q ? '0 : mem_rdata;
                    d_abort  <= mem_abort;
                end else begin
                    i_rvalid <= 1'b1;
                    i_rdata  <= mem_rdata;
                    i_abort  <= mem_abort;
                end
            end
        end
    end

endmodule
